// File: rtl/copperv_pkg.sv
// Shared bus types for the copperv core and its memory-side responder.
package copperv_pkg;

    typedef enum logic {
        resp_ok  = 1'b0,
        resp_err = 1'b1
    } bus_resp_e;

    typedef enum logic [1:0] {
        resp_idle    = 2'd0,
        resp_wait    = 2'd1,
        resp_respond = 2'd2
    } responder_state_e;

    typedef enum logic [1:0] {
        ch_ir = 2'd0,
        ch_dr = 2'd1,
        ch_dw = 2'd2
    } responder_ch_e;

endpackage

// File: rtl/sram_array.sv
// Word-addressed storage with a registered read port and a byte-strobed write port.
module sram_array #(
    parameter int    DEPTH     = 1024,
    parameter int    DATA_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_strobe
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents and the read register survive a bus reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_strobe[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Bus responder: arbitrates ir/dr/dw requests, waits a fixed latency, then answers
// from the internal SRAM. One request in flight at a time.
module sram_responder
    import copperv_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_addr_valid,
    output logic              ir_addr_ready,
    input  logic [ADDR_W-1:0] ir_addr,
    output logic              ir_data_valid,
    input  logic              ir_data_ready,
    output logic [DATA_W-1:0] ir_data,
    input  logic              dr_addr_valid,
    output logic              dr_addr_ready,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_data_valid,
    input  logic              dr_data_ready,
    output logic [DATA_W-1:0] dr_data,
    input  logic              dw_valid,
    output logic              dw_ready,
    input  logic [ADDR_W-1:0] dw_addr,
    input  logic [DATA_W-1:0] dw_data,
    input  logic [3:0]        dw_strobe,
    output logic              dw_resp_valid,
    input  logic              dw_resp_ready,
    output bus_resp_e         dw_resp
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    responder_state_e  state, state_next;
    logic [3:0]        cnt, cnt_next;

    responder_ch_e     ch;
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;

    logic              accept;
    responder_ch_e     acc_ch;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_oor;

    logic              do_access;
    responder_ch_e     mem_ch;
    logic [IDX_W-1:0]  mem_idx;
    logic              mem_oor;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic              resp_ready;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{ir_addr[1:0], dr_addr[1:0], dw_addr[1:0]};

    assign acc_oor = |acc_addr[ADDR_W-1:IDX_W+2];

    always_comb begin
        case (ch)
            ch_dw:   resp_ready = dw_resp_ready;
            ch_dr:   resp_ready = dr_data_ready;
            default: resp_ready = ir_data_ready;
        endcase
    end

    always_comb begin
        ir_addr_ready = 1'b0;
        dr_addr_ready = 1'b0;
        dw_ready      = 1'b0;
        accept        = 1'b0;
        acc_ch        = ch_ir;
        acc_addr      = ir_addr;
        state_next    = state;
        cnt_next      = cnt;
        do_access     = 1'b0;

        case (state)
            resp_idle: begin
                // Gated by rst so nothing is granted while reset is held.
                if (!rst) begin
                    if (dw_valid) begin
                        dw_ready = 1'b1;
                        accept   = 1'b1;
                        acc_ch   = ch_dw;
                        acc_addr = dw_addr;
                    end else if (dr_addr_valid) begin
                        dr_addr_ready = 1'b1;
                        accept        = 1'b1;
                        acc_ch        = ch_dr;
                        acc_addr      = dr_addr;
                    end else if (ir_addr_valid) begin
                        ir_addr_ready = 1'b1;
                        accept        = 1'b1;
                    end
                end
                if (accept) begin
                    cnt_next = LAT_M1;
                    if (LATENCY == 1) begin
                        do_access  = 1'b1;
                        state_next = resp_respond;
                    end else begin
                        state_next = resp_wait;
                    end
                end
            end
            resp_wait: begin
                // The access is issued on the cycle the counter reaches zero.
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    do_access  = 1'b1;
                    state_next = resp_respond;
                end
            end
            resp_respond: begin
                if (resp_ready) begin
                    state_next = resp_idle;
                end
            end
            default: state_next = resp_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= resp_idle;
            cnt   <= 4'd0;
            ch    <= ch_ir;
            idx   <= '0;
            oor   <= 1'b0;
            wdata <= '0;
            wstrb <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                ch    <= acc_ch;
                idx   <= acc_addr[IDX_W+1:2];
                oor   <= acc_oor;
                wdata <= dw_data;
                wstrb <= dw_strobe;
            end
        end
    end

    // With LATENCY=1 the access happens on the acceptance edge, straight from the bus.
    always_comb begin
        if (state == resp_idle) begin
            mem_ch    = acc_ch;
            mem_idx   = acc_addr[IDX_W+1:2];
            mem_oor   = acc_oor;
            mem_wdata = dw_data;
            mem_wstrb = dw_strobe;
        end else begin
            mem_ch    = ch;
            mem_idx   = idx;
            mem_oor   = oor;
            mem_wdata = wdata;
            mem_wstrb = wstrb;
        end
    end

    assign mem_rd_en = do_access && (mem_ch != ch_dw) && !mem_oor;
    assign mem_wr_en = do_access && (mem_ch == ch_dw) && !mem_oor;

    sram_array #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk       (clk),
        .rd_en     (mem_rd_en),
        .rd_idx    (mem_idx),
        .rd_data   (mem_rd_data),
        .wr_en     (mem_wr_en),
        .wr_idx    (mem_idx),
        .wr_data   (mem_wdata),
        .wr_strobe (mem_wstrb)
    );

    // Responses depend only on registered state and the SRAM read register.
    assign ir_data_valid = (state == resp_respond) && (ch == ch_ir);
    assign dr_data_valid = (state == resp_respond) && (ch == ch_dr);
    assign dw_resp_valid = (state == resp_respond) && (ch == ch_dw);
    assign ir_data       = (ir_data_valid && !oor) ? mem_rd_data : '0;
    assign dr_data       = (dr_data_valid && !oor) ? mem_rd_data : '0;
    assign dw_resp       = (dw_resp_valid && oor) ? resp_err : resp_ok;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table plus arbitration, backpressure and reset sequences.
module tb_sram_responder;
    import copperv_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir_addr_valid = 0, ir_addr_ready, ir_data_valid, ir_data_ready = 0;
    logic [31:0] ir_addr = 0, ir_data;
    logic        dr_addr_valid = 0, dr_addr_ready, dr_data_valid, dr_data_ready = 0;
    logic [31:0] dr_addr = 0, dr_data;
    logic        dw_valid = 0, dw_ready, dw_resp_valid, dw_resp_ready = 0;
    logic [31:0] dw_addr = 0, dw_data = 0;
    logic [3:0]  dw_strobe = 0;
    bus_resp_e   dw_resp;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
        .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
        .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
        .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_data(dw_data),
        .dw_strobe(dw_strobe), .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready),
        .dw_resp(dw_resp)
    );

    typedef struct {
        responder_ch_e c;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        logic [31:0]   exp_rd;
        bus_resp_e     exp_rsp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic req_ready(input responder_ch_e c);
        case (c)
            ch_dw:   return dw_ready;
            ch_dr:   return dr_addr_ready;
            default: return ir_addr_ready;
        endcase
    endfunction

    function automatic logic rsp_valid(input responder_ch_e c);
        case (c)
            ch_dw:   return dw_resp_valid;
            ch_dr:   return dr_data_valid;
            default: return ir_data_valid;
        endcase
    endfunction

    function automatic logic [31:0] rsp_data(input responder_ch_e c);
        case (c)
            ch_dw:   return 32'(dw_resp);
            ch_dr:   return dr_data;
            default: return ir_data;
        endcase
    endfunction

    task automatic set_rsp_ready(input responder_ch_e c, input logic v);
        case (c)
            ch_dw:   dw_resp_ready = v;
            ch_dr:   dr_data_ready = v;
            default: ir_data_ready = v;
        endcase
    endtask

    // Issue one request, measure acceptance-to-valid, hold the response ready low for 'hold' cycles.
    task automatic transact(input responder_ch_e c, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold,
                            output logic [31:0] rd, output int lat, output logic stable);
        int  hs;
        bit  got;
        hs = 0; rd = 0; lat = -1; stable = 1'b1;
        @(negedge clk);
        case (c)
            ch_dw:   begin dw_valid = 1; dw_addr = addr; dw_data = data; dw_strobe = strb; end
            ch_dr:   begin dr_addr_valid = 1; dr_addr = addr; end
            default: begin ir_addr_valid = 1; ir_addr = addr; end
        endcase
        #1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (req_ready(c)) begin got = 1; hs = cyc; end
            else begin @(negedge clk); #1; end
        end
        if (!got) timeout("req_ready");
        @(posedge clk); #1;
        dw_valid = 0; dr_addr_valid = 0; ir_addr_valid = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid(c)) got = 1;
        end
        if (!got) begin
            timeout("rsp_valid");
            return;
        end
        lat = cyc - hs;
        rd  = rsp_data(c);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid(c) || rsp_data(c) !== rd) stable = 1'b0;
        end
        set_rsp_ready(c, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(c, 1'b0);
    endtask

    logic [31:0] rd;
    int          lat;
    logic        stable;
    int          g_dw, g_dr, g_ir, multi, late_valid;
    logic [31:0] dr_seen, ir_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a write request pending to prove no grant under reset.
        dw_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, dw_ready}, 32'd0);
        check("reset_valids", {29'd0, ir_data_valid, dr_data_valid, dw_resp_valid}, 32'd0);
        check("reset_ir_data", ir_data, 32'd0);
        check("reset_dr_data", dr_data, 32'd0);
        check("reset_dw_resp", 32'(dw_resp), 32'(resp_ok));
        dw_valid = 0;
        @(negedge clk);
        rst = 0;

        vecs.push_back('{ch_dw, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 32'h0, resp_ok});
        vecs.push_back('{ch_ir, 32'h0000_0040, 32'h0,         4'b0000, 32'hDEAD_BEEF, resp_ok});
        vecs.push_back('{ch_dw, 32'h0000_0080, 32'h0,         4'b1111, 32'h0, resp_ok});
        vecs.push_back('{ch_dw, 32'h0000_0080, 32'h1122_3344, 4'b0101, 32'h0, resp_ok});
        vecs.push_back('{ch_dr, 32'h0000_0080, 32'h0,         4'b0000, 32'h0022_0044, resp_ok});
        vecs.push_back('{ch_dw, 32'h0000_0080, 32'hAABB_CCDD, 4'b0000, 32'h0, resp_ok});
        vecs.push_back('{ch_dr, 32'h0000_0080, 32'h0,         4'b0000, 32'h0022_0044, resp_ok});
        vecs.push_back('{ch_dw, 32'h0000_0082, 32'hAABB_CCDD, 4'b1000, 32'h0, resp_ok});
        vecs.push_back('{ch_ir, 32'h0000_0083, 32'h0,         4'b0000, 32'hAA22_0044, resp_ok});
        vecs.push_back('{ch_dr, 32'h0000_0041, 32'h0,         4'b0000, 32'hDEAD_BEEF, resp_ok});
        vecs.push_back('{ch_dw, 32'h0000_0000, 32'h5555_5555, 4'b1111, 32'h0, resp_ok});
        vecs.push_back('{ch_dw, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h0, resp_err});
        vecs.push_back('{ch_dr, 32'h0000_1000, 32'h0,         4'b0000, 32'h0, resp_ok});
        vecs.push_back('{ch_ir, 32'h0000_1000, 32'h0,         4'b0000, 32'h0, resp_ok});
        vecs.push_back('{ch_dr, 32'h0000_0000, 32'h0,         4'b0000, 32'h5555_5555, resp_ok});
        vecs.push_back('{ch_dw, 32'h8000_0040, 32'h0BAD_0BAD, 4'b1111, 32'h0, resp_err});
        vecs.push_back('{ch_dr, 32'h0000_0040, 32'h0,         4'b0000, 32'hDEAD_BEEF, resp_ok});
        vecs.push_back('{ch_dw, 32'h0000_0FFC, 32'hFEED_FACE, 4'b1111, 32'h0, resp_ok});
        vecs.push_back('{ch_ir, 32'h0000_0FFC, 32'h0,         4'b0000, 32'hFEED_FACE, resp_ok});

        foreach (vecs[i]) begin
            transact(vecs[i].c, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, rd, lat, stable);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            if (vecs[i].c == ch_dw) check($sformatf("vec%0d_dw_resp", i), rd, 32'(vecs[i].exp_rsp));
            else                    check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // All three channels request together; write to 0x100 must be visible to the read.
        g_dw = -1; g_dr = -1; g_ir = -1; multi = 0; dr_seen = 0; ir_seen = 0;
        ir_data_ready = 1; dr_data_ready = 1; dw_resp_ready = 1;
        @(negedge clk);
        dw_valid = 1; dw_addr = 32'h100; dw_data = 32'hCAFE_F00D; dw_strobe = 4'b1111;
        dr_addr_valid = 1; dr_addr = 32'h100;
        ir_addr_valid = 1; ir_addr = 32'h40;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (int'(dw_ready) + int'(dr_addr_ready) + int'(ir_addr_ready) > 1) multi++;
            if (dr_data_valid) dr_seen = dr_data;
            if (ir_data_valid) ir_seen = ir_data;
            if (dw_ready) g_dw = cyc;
            if (dr_addr_ready) g_dr = cyc;
            if (ir_addr_ready) g_ir = cyc;
            @(posedge clk); #1;
            if (dw_ready_was(g_dw)) dw_valid = 0;
            if (g_dr >= 0) dr_addr_valid = 0;
            if (g_ir >= 0) ir_addr_valid = 0;
            @(negedge clk);
        end
        ir_data_ready = 0; dr_data_ready = 0; dw_resp_ready = 0;
        check("arb_dw_granted", {31'd0, g_dw >= 0}, 32'd1);
        check("arb_gap_dw_dr", 32'(g_dr - g_dw), 32'(LAT + 1));
        check("arb_gap_dr_ir", 32'(g_ir - g_dr), 32'(LAT + 1));
        check("arb_one_ready", 32'(multi), 32'd0);
        check("arb_dr_new_data", dr_seen, 32'hCAFE_F00D);
        check("arb_ir_data", ir_seen, 32'hDEAD_BEEF);

        // Backpressure: response ready held low for 5 cycles.
        transact(ch_dr, 32'h40, 32'h0, 4'b0000, 5, rd, lat, stable);
        check("hold_latency", 32'(lat), 32'(LAT));
        check("hold_data", rd, 32'hDEAD_BEEF);
        check("hold_stable", {31'd0, stable}, 32'd1);
        check("hold_idle_after", 32'(dut.state), 32'(resp_idle));

        // Reset while the request is waiting: no response ever appears.
        @(negedge clk);
        dr_addr_valid = 1; dr_addr = 32'h40;
        #1;
        check("rstwait_accept", {31'd0, dr_addr_ready}, 32'd1);
        @(posedge clk); #1;
        dr_addr_valid = 0;
        dr_data_ready = 1;
        @(negedge clk);
        check("rstwait_in_wait", 32'(dut.state), 32'(resp_wait));
        rst = 1; dw_valid = 1; dw_addr = 32'h40; dw_data = 32'h0; dw_strobe = 4'b1111;
        @(posedge clk); #1;
        check("rstwait_readies", {29'd0, ir_addr_ready, dr_addr_ready, dw_ready}, 32'd0);
        check("rstwait_valids", {29'd0, ir_data_valid, dr_data_valid, dw_resp_valid}, 32'd0);
        check("rstwait_data", ir_data | dr_data, 32'd0);
        check("rstwait_dw_resp", 32'(dw_resp), 32'(resp_ok));
        dw_valid = 0;
        @(negedge clk);
        rst = 0;
        late_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ir_data_valid || dr_data_valid || dw_resp_valid) late_valid++;
        end
        dr_data_ready = 0;
        check("rstwait_no_response", 32'(late_valid), 32'd0);
        transact(ch_dr, 32'h40, 32'h0, 4'b0000, 0, rd, lat, stable);
        check("rstwait_mem_kept", rd, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic dw_ready_was(input int g);
        return g >= 0;
    endfunction

endmodule
